// File: rtl/tracker_pkg.sv
// Purpose: shared mode codes, route codes and FSM state type for the line tracker and motor controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: MODE_* codes (5 bit), ROUTE_* codes (2 bit), state_t, follow_next() pattern helper.
package tracker_pkg;

  localparam logic [4:0] MODE_IDLE              = 5'd0;
  localparam logic [4:0] MODE_START             = 5'd1;
  localparam logic [4:0] MODE_COUNT             = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT          = 5'd3;
  localparam logic [4:0] MODE_CHOOSE            = 5'd4;
  localparam logic [4:0] MODE_TURN_STRAIGHT     = 5'd5;
  localparam logic [4:0] MODE_TURN_LEFT         = 5'd6;
  localparam logic [4:0] MODE_TURN_RIGHT        = 5'd7;
  localparam logic [4:0] MODE_TURN_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] MODE_TURN_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] MODE_STOP              = 5'd30;
  localparam logic [4:0] MODE_ERROR             = 5'd31;

  localparam logic [1:0] ROUTE_THROUGH = 2'b00;
  localparam logic [1:0] ROUTE_LEFT    = 2'b01;
  localparam logic [1:0] ROUTE_RIGHT   = 2'b10;
  localparam logic [1:0] ROUTE_STOP    = 2'b11;

  // State encoding equals the mode code so the mode output is the state register itself.
  typedef enum logic [4:0] {
    ST_IDLE              = MODE_IDLE,
    ST_START             = MODE_START,
    ST_COUNT             = MODE_COUNT,
    ST_STRAIGHT          = MODE_STRAIGHT,
    ST_CHOOSE            = MODE_CHOOSE,
    ST_TURN_STRAIGHT     = MODE_TURN_STRAIGHT,
    ST_TURN_LEFT         = MODE_TURN_LEFT,
    ST_TURN_RIGHT        = MODE_TURN_RIGHT,
    ST_TURN_LITTLE_LEFT  = MODE_TURN_LITTLE_LEFT,
    ST_TURN_LITTLE_RIGHT = MODE_TURN_LITTLE_RIGHT,
    ST_STOP              = MODE_STOP,
    ST_ERROR             = MODE_ERROR
  } state_t;

  // Line-following reaction to a filtered {L,M,R} pattern; 000 and 101 hold the current state.
  function automatic state_t follow_next(input logic [2:0] pat, input state_t cur);
    state_t res;
    res = cur;
    case (pat)
      3'b010:         res = ST_STRAIGHT;
      3'b100, 3'b110: res = ST_TURN_LITTLE_LEFT;
      3'b001, 3'b011: res = ST_TURN_LITTLE_RIGHT;
      3'b111:         res = ST_CHOOSE;
      default:        res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// Purpose: synchronise the asynchronous 3-bit IR sensor bus and accept a pattern only once stable.
// Latency: 2 + FILTER_CYCLES cycles from a raw change to the filtered output.
// Backpressure: none; free-running, any change of the synchronised value restarts the count.
// Ports: clk, rst (async, active-high), raw[2:0] {L,M,R} asynchronous, filtered[2:0] accepted pattern.
module sensor_filter #(
  parameter int FILTER_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw,
  output logic [2:0] filtered
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW:0] FILTER_LIM = (CW + 1)'(FILTER_CYCLES);

  logic [2:0]    sync1, sync2, cand;
  logic [CW-1:0] cnt;
  logic [CW:0]   samples;

  // Number of consecutive equal synchronised samples including the current one.
  always_comb samples = (sync2 == cand) ? ({1'b0, cnt} + 1'b1) : (CW + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      filtered <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cand  <= sync2;
      if (samples >= FILTER_LIM) begin
        filtered <= sync2;
        cnt      <= CW'(FILTER_CYCLES);  // saturate while the pattern stays put
      end else begin
        cnt <= samples[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/line_tracker_fsm.sv
// Purpose: line-tracking mode generator feeding the motor controller (filter + route-table FSM).
// Latency: mode/last_mode registered, one cycle after the filtered pattern that causes a change.
// Backpressure: none; start is a one-cycle pulse honoured only in IDLE, STOP and ERROR.
// Ports: clk, rst (async, active-high), start, sensor[2:0] raw {L,M,R}, [obstacle],
//        mode[4:0], last_mode[4:0] (state just left, one cycle), node_count[7:0].
// Optional: define TRACKER_OBSTACLE_EN to add the obstacle input that forces STOP while following.
module line_tracker_fsm
  import tracker_pkg::*;
#(
  parameter int FILTER_CYCLES   = 100_000,
  parameter int COUNT_CYCLES    = 100_000_000,
  parameter int MIN_TURN_CYCLES = 20_000_000,
  parameter int TURN_TIMEOUT    = 300_000_000,
  parameter int LOST_CYCLES     = 50_000_000,
  parameter int NUM_NODES       = 8,
  parameter logic [2*NUM_NODES-1:0] ROUTE = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef TRACKER_OBSTACLE_EN
  input  logic       obstacle,
`endif
  input  logic [2:0] sensor,
  output logic [4:0] mode,
  output logic [4:0] last_mode,
  output logic [7:0] node_count
);

  localparam int CW = $clog2(COUNT_CYCLES + 1);
  localparam int TW = $clog2(TURN_TIMEOUT + 1);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam int IW = $clog2(NUM_NODES + 1);

  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(TURN_TIMEOUT - 1);
  localparam logic [TW-1:0] DWELL_MIN  = TW'(MIN_TURN_CYCLES);
  localparam logic [LW-1:0] LOST_LAST  = LW'(LOST_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END    = IW'(NUM_NODES);

  state_t                 state, nxt;
  logic [2:0]             filt;
  logic [CW-1:0]          count_cnt;
  logic [TW-1:0]          dwell_cnt;
  logic [LW-1:0]          lost_cnt;
  logic [IW-1:0]          route_idx;
  logic [2*NUM_NODES-1:0] route_shift;
  logic [1:0]             route_code;
  logic                   follow_st, turn_st, timeout, lost_hit;

  sensor_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .raw      (sensor),
    .filtered (filt)
  );

  assign mode        = state;
  assign route_shift = ROUTE >> {route_idx, 1'b0};
  assign route_code  = route_shift[1:0];

  assign follow_st = (state == ST_STRAIGHT) || (state == ST_TURN_LITTLE_LEFT) ||
                     (state == ST_TURN_LITTLE_RIGHT);
  assign turn_st   = (state == ST_TURN_STRAIGHT) || (state == ST_TURN_LEFT) ||
                     (state == ST_TURN_RIGHT) || (state == ST_TURN_LITTLE_LEFT) ||
                     (state == ST_TURN_LITTLE_RIGHT);
  // Both fire on the edge at which the counter would reach its limit.
  assign timeout   = turn_st && (dwell_cnt == DWELL_LAST);
  assign lost_hit  = follow_st && (filt == 3'b000) && (lost_cnt == LOST_LAST);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_STOP, ST_ERROR: if (start) nxt = ST_START;
      ST_START:                   nxt = ST_COUNT;
      ST_COUNT:                   if (count_cnt == COUNT_LAST) nxt = ST_STRAIGHT;
      ST_STRAIGHT, ST_TURN_LITTLE_LEFT, ST_TURN_LITTLE_RIGHT: begin
        if (timeout || lost_hit) nxt = ST_ERROR;
        else                     nxt = follow_next(filt, state);
      end
      ST_CHOOSE: begin
        if (route_idx == IDX_END) begin
          nxt = ST_STOP;
        end else begin
          case (route_code)
            ROUTE_THROUGH: nxt = ST_TURN_STRAIGHT;
            ROUTE_LEFT:    nxt = ST_TURN_LEFT;
            ROUTE_RIGHT:   nxt = ST_TURN_RIGHT;
            ROUTE_STOP:    nxt = ST_STOP;
          endcase
        end
      end
      ST_TURN_STRAIGHT: begin
        if (timeout)               nxt = ST_ERROR;
        else if (filt != 3'b111)   nxt = ST_STRAIGHT;
      end
      ST_TURN_LEFT, ST_TURN_RIGHT: begin
        if (timeout)                                     nxt = ST_ERROR;
        else if (dwell_cnt >= DWELL_MIN && filt == 3'b010) nxt = ST_STRAIGHT;
      end
      default: nxt = ST_ERROR;
    endcase
`ifdef TRACKER_OBSTACLE_EN
    // Hard turns are committed; the obstacle only stops the car while it follows the line.
    if (obstacle && (follow_st || state == ST_TURN_STRAIGHT)) nxt = ST_STOP;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_mode  <= '0;
      node_count <= '0;
      route_idx  <= '0;
      count_cnt  <= '0;
      dwell_cnt  <= '0;
      lost_cnt   <= '0;
    end else begin
      state     <= nxt;
      last_mode <= (nxt != state) ? mode : MODE_IDLE;
      if (nxt != state) begin
        count_cnt <= '0;
        dwell_cnt <= '0;
        lost_cnt  <= '0;
      end else begin
        if (state == ST_COUNT) count_cnt <= count_cnt + 1'b1;
        if (turn_st)           dwell_cnt <= dwell_cnt + 1'b1;
        if (follow_st)         lost_cnt  <= (filt == 3'b000) ? lost_cnt + 1'b1 : '0;
      end
      if (nxt == ST_START) begin
        route_idx  <= '0;
        node_count <= '0;
      end else if (state == ST_CHOOSE) begin
        if (route_idx != IDX_END) route_idx  <= route_idx + 1'b1;
        if (node_count != 8'hFF)  node_count <= node_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_tracker_fsm.sv
module tb_line_tracker_fsm;

  localparam int F  = 4;
  localparam int CC = 10;
  localparam int MT = 8;
  localparam int TO = 50;
  localparam int LC = 20;
  localparam int NN = 2;
  localparam logic [3:0] RT = 4'b1001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] sensor = 3'b000;
  logic [4:0] mode, last_mode;
  logic [7:0] node_count;
  logic       obs_s;
`ifdef TRACKER_OBSTACLE_EN
  logic       obstacle = 1'b0;
  assign obs_s = obstacle;
`else
  assign obs_s = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_tracker_fsm #(
    .FILTER_CYCLES(F), .COUNT_CYCLES(CC), .MIN_TURN_CYCLES(MT), .TURN_TIMEOUT(TO),
    .LOST_CYCLES(LC), .NUM_NODES(NN), .ROUTE(RT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef TRACKER_OBSTACLE_EN
    .obstacle   (obstacle),
`endif
    .sensor     (sensor),
    .mode       (mode),
    .last_mode  (last_mode),
    .node_count (node_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [2:0] hist[$];   // raw samples still travelling through the synchroniser
  logic [2:0] run_val;
  int         run_len;
  logic [2:0] m_filt;
  int m_mode, m_last, m_nodes, m_idx, m_cyc, m_lost;

  task automatic model_reset();
    hist = {3'b000, 3'b000};
    run_val = 3'b000; run_len = 0; m_filt = 3'b000;
    m_mode = 0; m_last = 0; m_nodes = 0; m_idx = 0; m_cyc = 0; m_lost = 0;
  endtask

  task automatic model_step(input logic [2:0] raw, input bit st, input bit obs);
    logic [2:0] f, seen;
    logic [3:0] rs;
    int nm;
    bit follow, turn;
    f = m_filt;                              // FSM reacts to the pattern accepted before this edge
    hist.push_back(raw);
    seen = hist.pop_front();
    if (seen == run_val) run_len++; else begin run_val = seen; run_len = 1; end
    if (run_len >= F) m_filt = seen;

    follow = (m_mode == 3 || m_mode == 8 || m_mode == 9);
    turn   = (m_mode >= 5 && m_mode <= 9);
    nm = m_mode;
    case (m_mode)
      0, 30, 31: if (st) nm = 1;
      1: nm = 2;
      2: if (m_cyc + 1 >= CC) nm = 3;
      3, 8, 9: begin
        if (turn && m_cyc + 1 >= TO) nm = 31;
        else if (f == 3'b000) begin if (m_lost + 1 >= LC) nm = 31; end
        else if (f == 3'b010) nm = 3;
        else if (f == 3'b100 || f == 3'b110) nm = 8;
        else if (f == 3'b001 || f == 3'b011) nm = 9;
        else if (f == 3'b111) nm = 4;
      end
      4: begin
        if (m_idx == NN) nm = 30;
        else begin
          rs = RT >> (2 * m_idx);
          nm = (rs[1:0] == 2'b00) ? 5 : (rs[1:0] == 2'b01) ? 6 : (rs[1:0] == 2'b10) ? 7 : 30;
        end
        if (m_idx != NN) m_idx++;
        if (m_nodes < 255) m_nodes++;
      end
      5: if (m_cyc + 1 >= TO) nm = 31; else if (f != 3'b111) nm = 3;
      6, 7: if (m_cyc + 1 >= TO) nm = 31; else if (m_cyc >= MT && f == 3'b010) nm = 3;
      default: nm = 31;
    endcase
    if (obs && (follow || m_mode == 5)) nm = 30;

    m_last = (nm != m_mode) ? m_mode : 0;
    if (nm != m_mode) begin m_cyc = 0; m_lost = 0; end
    else begin m_cyc++; m_lost = (follow && f == 3'b000) ? m_lost + 1 : 0; end
    if (nm == 1 && m_mode != 1) begin m_nodes = 0; m_idx = 0; end
    m_mode = nm;
  endtask

  // One compare process: every cycle, advance the model and compare all outputs.
  always @(posedge clk) begin
    #1;
    if (rst) model_reset();
    else     model_step(sensor, start, obs_s);
    check("mode", int'(mode), m_mode);
    check("last_mode", int'(last_mode), m_last);
    check("node_count", int'(node_count), m_nodes);
  end

  // Waits at negedges until mode equals target; n = negedges elapsed.
  task automatic wait_mode(input string name, input int target, input int limit, output int n);
    n = 0;
    while (int'(mode) != target && n < limit) begin @(negedge clk); n++; end
    if (int'(mode) != target) begin
      checks++; failures++;
      $display("FAIL %s: mode %0d never reached %0d within %0d cycles", name, mode, target, limit);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad, r, hold;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_mode", int'(mode), 0);
    check("reset_last", int'(last_mode), 0);
    check("reset_nodes", int'(node_count), 0);
    rst = 1'b0;
    sensor = 3'b010;
    repeat (8) @(negedge clk);
    check("idle_hold", int'(mode), 0);

    // Start sequence: START one cycle, COUNT for CC cycles, then STRAIGHT.
    pulse_start();
    check("start_mode", int'(mode), 1);
    check("start_last", int'(last_mode), 0);
    @(negedge clk);
    check("count_mode", int'(mode), 2);
    check("count_last", int'(last_mode), 1);
    n = 0;
    while (mode == 5'd2 && n < 40) begin n++; @(negedge clk); end
    check("count_len", n, CC);
    check("straight_mode", int'(mode), 3);
    check("straight_last", int'(last_mode), 2);
    @(negedge clk);
    check("last_pulse_width", int'(last_mode), 0);

    // Line following: 2 sync + F filter + 1 registered FSM = 7 cycles per reaction.
    sensor = 3'b110; wait_mode("to_little_left", 8, 40, n);  check("lat_little_left", n, 2 + F + 1);
    sensor = 3'b010; wait_mode("to_straight", 3, 40, n);     check("lat_straight", n, 2 + F + 1);
    sensor = 3'b011; wait_mode("to_little_right", 9, 40, n); check("lat_little_right", n, 2 + F + 1);
    sensor = 3'b010; wait_mode("back_straight", 3, 40, n);
    repeat (10) @(negedge clk);
    sensor = 3'b110; repeat (3) @(negedge clk); sensor = 3'b010;
    bad = 0;
    repeat (12) begin @(negedge clk); if (mode != 5'd3) bad++; end
    check("glitch_ignored", bad, 0);

    // First intersection: route entry 0 = left.
    sensor = 3'b111; wait_mode("choose1", 4, 40, n);
    @(negedge clk);
    check("left_mode", int'(mode), 6);
    check("left_last", int'(last_mode), 4);
    check("left_nodes", int'(node_count), 1);
    sensor = 3'b010; wait_mode("left_exit", 3, 60, n);
    check("left_dwell", n, MT + 1);
    check("left_exit_last", int'(last_mode), 6);
    @(negedge clk);
    check("left_exit_pulse", int'(last_mode), 0);

    // Second intersection right, third ends the route.
    sensor = 3'b111; wait_mode("choose2", 4, 40, n);
    @(negedge clk);
    check("right_mode", int'(mode), 7);
    check("right_nodes", int'(node_count), 2);
    sensor = 3'b010; wait_mode("right_exit", 3, 60, n);
    sensor = 3'b111; wait_mode("choose3", 4, 40, n);
    @(negedge clk);
    check("route_end_mode", int'(mode), 30);
    check("route_end_nodes", int'(node_count), 3);
    sensor = 3'b010;
    repeat (3) @(negedge clk);
    check("stop_sticky", int'(mode), 30);
    pulse_start();
    check("restart_mode", int'(mode), 1);
    check("restart_nodes", int'(node_count), 0);

    // Lost line in STRAIGHT.
    wait_mode("lost_setup", 3, 40, n);
    sensor = 3'b000; wait_mode("lost_error", 31, 80, n);
    check("lost_latency", n, 2 + F + LC);

    // Turn timeout in TURN_RIGHT.
    sensor = 3'b010; pulse_start();
    wait_mode("to_setup", 3, 40, n);
    sensor = 3'b111; wait_mode("to_choose1", 4, 40, n); @(negedge clk);
    sensor = 3'b010; wait_mode("to_exit1", 3, 60, n);
    sensor = 3'b111; wait_mode("to_choose2", 4, 40, n); @(negedge clk);
    check("to_right", int'(mode), 7);
    sensor = 3'b000; wait_mode("to_error", 31, 100, n);
    check("turn_timeout", n, TO);

    // Asynchronous reset in the middle of a turn.
    sensor = 3'b010; pulse_start();
    wait_mode("rst_setup", 3, 40, n);
    sensor = 3'b111; wait_mode("rst_choose", 4, 40, n);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_nodes", int'(node_count), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sensor = 3'b010;
    repeat (8) @(negedge clk);

`ifdef TRACKER_OBSTACLE_EN
    pulse_start();
    wait_mode("obs_setup", 3, 40, n);
    obstacle = 1'b1; @(negedge clk); obstacle = 1'b0;
    check("obs_stop", int'(mode), 30);
    check("obs_last", int'(last_mode), 3);
    pulse_start();
    wait_mode("obs_setup2", 3, 40, n);
    sensor = 3'b111; wait_mode("obs_choose", 4, 40, n); @(negedge clk);
    obstacle = 1'b1;
    bad = 0;
    repeat (4) begin @(negedge clk); if (mode != 5'd6) bad++; end
    obstacle = 1'b0;
    check("obs_in_turn_ignored", bad, 0);
    sensor = 3'b010;
    repeat (12) @(negedge clk);
`endif

    // Randomised phase, checked every cycle against the model.
    for (int c = 0; c < 5000; ) begin
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 14);
      if      (r < 45) sensor = 3'b010;
      else if (r < 55) sensor = 3'b110;
      else if (r < 61) sensor = 3'b100;
      else if (r < 71) sensor = 3'b011;
      else if (r < 77) sensor = 3'b001;
      else if (r < 86) sensor = 3'b111;
      else if (r < 94) sensor = 3'b000;
      else             sensor = 3'b101;
      for (int h = 0; h < hold; h++) begin
        if (mode == 5'd0 || mode == 5'd30 || mode == 5'd31) start = ($urandom_range(0, 7) == 0);
        else                                                start = ($urandom_range(0, 59) == 0);
`ifdef TRACKER_OBSTACLE_EN
        obstacle = ($urandom_range(0, 59) == 0);
`endif
        rst = (c >= 2500 && c < 2502);
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
